rf_rename_ooo: RTL and testbench
================================

Name: rf_rename_ooo

Overview:
- Parametrised architectural register file with per-register rename tags for the Tomasulo back end.
- Sits between the decoder and the reservation stations/ROB. Reads two operands per dispatched instruction and returns each as a value or a busy ROB tag.
- Records the destination tag of each dispatched instruction and retires values on ROB commit.
- Successor to the fixed-size PC-tagged register file. Adds:
  - explicit busy bits and parametrised tag, data and register widths;
  - a valid/ready output stage with back-pressure;
  - same-cycle commit-to-read forwarding.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- REG_ADDR_W, 5, register index width; must satisfy 2^REG_ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.
- TAG_W, 4, ROB tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  ROB exception/mispredict flush.
- disp_valid  in  1  decoder presents an instruction.
- disp_ready  out  1  block accepts the instruction this cycle.
- disp_rs1  in  REG_ADDR_W  source register 1.
- disp_rs2  in  REG_ADDR_W  source register 2.
- disp_rd  in  REG_ADDR_W  destination register.
- disp_tag  in  TAG_W  ROB tag allocated to the instruction.
- commit_valid  in  1  ROB commits this cycle.
- commit_rd  in  REG_ADDR_W  committed destination register.
- commit_tag  in  TAG_W  committed ROB tag.
- commit_data  in  DATA_W  committed value.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  reservation station consumes the bundle.
- out_v1, out_v2  out  DATA_W  operand values; meaningful when the matching busy bit is 0.
- out_q1, out_q2  out  TAG_W  producer tags; meaningful when the matching busy bit is 1.
- out_b1, out_b2  out  1  operand still pending.
- out_rd  out  REG_ADDR_W  registered destination register.
- out_tag  out  TAG_W  registered ROB tag.

Behaviour:
- Reset (rst=0, asynchronous):
  - all register values, busy bits and tags are cleared to 0;
  - out_valid=0; every out_* data field is 0;
  - disp_ready reads 1 once rst is released.
- State held per register: value[DATA_W], busy, tag[TAG_W]. Register 0 always reads value 0 with busy=0 and is never renamed or written.
- Accept rule: a dispatch is accepted when disp_valid & disp_ready.
  - disp_ready = !flush & (!out_valid | out_ready).
- Output stage:
  - one-stage pipeline; latency 1 cycle from acceptance to out_valid=1;
  - back-to-back accepts give full throughput;
  - while out_valid=1 and out_ready=0, every out_* field holds stable.
  - out_valid clears on a consume cycle (out_valid & out_ready) that has no new accept.
- Commit, when commit_valid and commit_rd!=0:
  - value[commit_rd] <= commit_data;
  - if busy[commit_rd] and tag[commit_rd]==commit_tag, busy is cleared;
  - if the tag does not match (the register was renamed again), busy and tag are left unchanged.
- Rename on accept, when disp_rd!=0: busy[disp_rd] <= 1 and tag[disp_rd] <= disp_tag.
- Operand read on accept, per source rs, using the state before this cycle's rename:
  - rs==0: v=0, b=0, q=0.
  - Commit forwarding applies when commit_valid, commit_rd==rs and rs!=0:
    - v = commit_data;
    - b = busy[rs] & (tag[rs]!=commit_tag);
    - q = tag[rs] if b=1, else 0.
  - Otherwise: v=value[rs], b=busy[rs], q = tag[rs] if b=1, else 0.
  - rs==disp_rd in the same instruction returns the old mapping (read before rename).
- Commit and rename to the same rd in the same cycle:
  - the value is written;
  - the rename wins: busy=1, tag=disp_tag.
- Flush:
  - next edge: all busy bits cleared, tags zeroed, out_valid=0;
  - no dispatch is accepted in the flush cycle;
  - a commit in the same cycle still writes its value.
- No arithmetic is performed. Tags are compared for equality over the full TAG_W bits; there is no wrap logic, because tag reuse is the ROB's responsibility.
- Reset asserted mid-operation clears everything immediately, including a stalled output bundle.

Test Plan:
- Reset, then dispatch rs1=3, rs2=0, rd=5, tag=2 -> one cycle later out_valid=1, out_v1=0, out_b1=0, out_b2=0, out_rd=5, out_tag=2.
- Dispatch rd=5 tag=2, then dispatch rs1=5 -> out_b1=1, out_q1=2. Then commit rd=5 tag=2 data=0xDEADBEEF and dispatch rs1=5 in the same cycle -> out_b1=0, out_v1=0xDEADBEEF.
- Rename x7 with tag 1, then with tag 4; commit rd=7 tag=1 data=9 -> x7 stays busy with tag 4; a later read gives b=1, q=4; the value array holds 9.
- Hold out_ready=0 for 3 cycles with disp_valid=1 -> disp_ready=0 and out_* stable throughout. Raise out_ready -> the next bundle appears the following cycle.
- Rename x1..x4, assert flush with commit rd=2 data=0x55 in the same cycle -> after the edge every register reads b=0, x2 reads 0x55, out_valid=0.
- Drop rst asynchronously between edges while out_valid=1 -> out_valid=0 immediately and all registers read 0.

Source files
------------

// File: rtl/rf_rename_ooo.sv
// rf_rename_ooo: architectural register file with per-register ROB rename tags and a valid/ready operand output stage.
module rf_rename_ooo #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [REG_ADDR_W-1:0] disp_rs1,
  input  logic [REG_ADDR_W-1:0] disp_rs2,
  input  logic [REG_ADDR_W-1:0] disp_rd,
  input  logic [TAG_W-1:0]      disp_tag,
  input  logic                  commit_valid,
  input  logic [REG_ADDR_W-1:0] commit_rd,
  input  logic [TAG_W-1:0]      commit_tag,
  input  logic [DATA_W-1:0]     commit_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_v1,
  output logic [DATA_W-1:0]     out_v2,
  output logic [TAG_W-1:0]      out_q1,
  output logic [TAG_W-1:0]      out_q2,
  output logic                  out_b1,
  output logic                  out_b2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [TAG_W-1:0]      out_tag
);
  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic              b;
    logic [TAG_W-1:0]  q;
  } op_t;
  logic [DATA_W-1:0]     val_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]     val_d [1:NUM_REGS-1];
  logic [TAG_W-1:0]      tag_q [1:NUM_REGS-1];
  logic [TAG_W-1:0]      tag_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]   busy_q, busy_d;
  logic                  ov_q, ov_d;
  op_t                   op1_q, op1_d, op2_q, op2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [TAG_W-1:0]      otag_q, otag_d;
  logic                  acc;
  // Reads the pre-rename mapping, forwarding a same-cycle commit to the source.
  function automatic op_t rd_op(input logic [REG_ADDR_W-1:0] rs);
    op_t  o;
    logic fw;
    o  = '0;
    fw = 1'b0;
    for (int i = 1; i < NUM_REGS; i++)
      if (rs == REG_ADDR_W'(i)) begin
        fw  = commit_valid && commit_rd == rs;
        o.v = fw ? commit_data : val_q[i];
        o.b = busy_q[i] && !(fw && tag_q[i] == commit_tag);
        o.q = o.b ? tag_q[i] : '0;
      end
    return o;
  endfunction
  always_comb begin
    disp_ready = !flush && (!ov_q || out_ready);
    acc        = disp_valid && disp_ready;
    ov_d       = acc || (ov_q && !out_ready && !flush);
    op1_d      = acc ? rd_op(disp_rs1) : op1_q;
    op2_d      = acc ? rd_op(disp_rs2) : op2_q;
    rd_d       = acc ? disp_rd : rd_q;
    otag_d     = acc ? disp_tag : otag_q;
  end
  // Rename is applied after commit so it wins on the same register; flush overrides both.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (commit_valid && commit_rd == REG_ADDR_W'(i)) begin
        val_d[i] = commit_data;
        if (busy_q[i] && tag_q[i] == commit_tag) busy_d[i] = 1'b0;
      end
      if (acc && disp_rd == REG_ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
        tag_d[i]  = disp_tag;
      end
      if (flush) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
      ov_q   <= 1'b0;
      op1_q  <= '0;
      op2_q  <= '0;
      rd_q   <= '0;
      otag_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      ov_q   <= ov_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      rd_q   <= rd_d;
      otag_q <= otag_d;
    end
  end
  assign out_valid = ov_q;
  assign out_v1    = op1_q.v;
  assign out_b1    = op1_q.b;
  assign out_q1    = op1_q.q;
  assign out_v2    = op2_q.v;
  assign out_b2    = op2_q.b;
  assign out_q2    = op2_q.q;
  assign out_rd    = rd_q;
  assign out_tag   = otag_q;
endmodule

// File: tb/tb_rf_rename_ooo.sv
// tb_rf_rename_ooo: directed checks of rename, commit forwarding, back-pressure, flush and async reset.
module tb_rf_rename_ooo;
  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready, commit_valid, out_valid, out_ready;
  logic [4:0]  disp_rs1, disp_rs2, disp_rd, commit_rd, out_rd;
  logic [3:0]  disp_tag, commit_tag, out_q1, out_q2, out_tag;
  logic [31:0] commit_data, out_v1, out_v2;
  logic        out_b1, out_b2;
  int          pass = 0, total = 0;
  rf_rename_ooo dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_v1(out_v1), .out_v2(out_v2), .out_q1(out_q1), .out_q2(out_q2),
    .out_b1(out_b1), .out_b2(out_b2), .out_rd(out_rd), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    flush = 0; disp_valid = 0; disp_rs1 = 0; disp_rs2 = 0; disp_rd = 0; disp_tag = 0;
    commit_valid = 0; commit_rd = 0; commit_tag = 0; commit_data = 0; out_ready = 1;
  endtask
  task automatic disp(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] tag);
    disp_valid = 1; disp_rs1 = rs1; disp_rs2 = rs2; disp_rd = rd; disp_tag = tag;
  endtask
  task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] data);
    commit_valid = 1; commit_rd = rd; commit_tag = tag; commit_data = data;
  endtask
  initial begin
    rst = 0;
    idle();
    cyc(); cyc();
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_v1", out_v1, 0);
    chk("rst_tag", out_tag, 0);
    rst = 1;
    #1;
    chk("rst_ready", disp_ready, 1);
    disp(3, 0, 5, 2);
    cyc();
    chk("d1_valid", out_valid, 1);
    chk("d1_v1", out_v1, 0);
    chk("d1_b1", out_b1, 0);
    chk("d1_b2", out_b2, 0);
    chk("d1_rd", out_rd, 5);
    chk("d1_tag", out_tag, 2);
    idle(); disp(5, 0, 0, 0);
    cyc();
    chk("x5_b1", out_b1, 1);
    chk("x5_q1", out_q1, 2);
    commit(5, 2, 32'hDEADBEEF);
    cyc();
    chk("fwd_b1", out_b1, 0);
    chk("fwd_v1", out_v1, 32'hDEADBEEF);
    chk("fwd_q1", out_q1, 0);
    idle(); disp(0, 5, 7, 1);
    cyc();
    chk("x5_v2", out_v2, 32'hDEADBEEF);
    chk("x5_b2", out_b2, 0);
    disp(0, 0, 7, 4);
    cyc();
    idle(); commit(7, 1, 9);
    cyc();
    chk("consume_clear", out_valid, 0);
    idle(); disp(7, 0, 0, 0);
    cyc();
    chk("x7_b1", out_b1, 1);
    chk("x7_q1", out_q1, 4);
    chk("x7_v1", out_v1, 9);
    disp(5, 7, 9, 3);
    cyc();
    out_ready = 0;
    disp(9, 0, 10, 6);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", disp_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_rd", out_rd, 9);
      chk("stall_tag", out_tag, 3);
      chk("stall_v1", out_v1, 32'hDEADBEEF);
      chk("stall_b2", out_b2, 1);
      chk("stall_q2", out_q2, 4);
      cyc();
    end
    out_ready = 1;
    #1;
    chk("unstall_ready", disp_ready, 1);
    cyc();
    chk("next_rd", out_rd, 10);
    chk("next_tag", out_tag, 6);
    chk("next_b1", out_b1, 1);
    chk("next_q1", out_q1, 3);
    idle(); disp(9, 0, 9, 8); commit(9, 3, 32'h77);
    cyc();
    chk("samerd_b1", out_b1, 0);
    chk("samerd_v1", out_v1, 32'h77);
    idle(); disp(9, 0, 0, 0);
    cyc();
    chk("rename_wins_b1", out_b1, 1);
    chk("rename_wins_q1", out_q1, 8);
    chk("rename_wins_v1", out_v1, 32'h77);
    for (int i = 1; i <= 4; i++) begin
      disp(0, 0, 5'(i), 4'(i));
      cyc();
    end
    idle(); flush = 1; disp(1, 2, 6, 5); commit(2, 9, 32'h55);
    #1;
    chk("flush_ready", disp_ready, 0);
    cyc();
    chk("flush_valid", out_valid, 0);
    idle();
    for (int i = 1; i < 32; i++) begin
      disp(5'(i), 0, 0, 0);
      cyc();
      chk("flush_b", out_b1, 0);
      chk("flush_q", out_q1, 0);
      if (i == 2) chk("flush_x2", out_v1, 32'h55);
    end
    out_ready = 0;
    disp(5, 0, 11, 1);
    cyc();
    chk("pre_rst_valid", out_valid, 1);
    #3;
    rst = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_v1", out_v1, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_tag", out_tag, 0);
    @(negedge clk);
    rst = 1;
    idle(); disp(5, 9, 0, 0);
    cyc();
    chk("arst_x5_v", out_v1, 0);
    chk("arst_x9_b", out_b2, 0);
    chk("arst_x9_v", out_v2, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
